tone_player: RTL and testbench

Parametrised note-playback engine for the piezo buzzer. It accepts one note command at a time over a valid/ready handshake and plays it for a programmed number of milliseconds. Each command carries a chromatic note (12 semitones plus rest), an octave, and a duration. The block sits between the melody sequencer and the board buzzer pin, and replaces the fixed 7-note, 2-pitch tone divider.

---
 rtl/tone_player.sv | 215 +++++++++++++++++++++
 tb/tb_tone_player.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_player.sv
// tone_player: note-playback engine for the piezo buzzer.
// Accepts one {note, octave, dur} command over valid/ready and plays a square
// wave for dur milliseconds, then (optionally) a fixed silent gap.
//
// Optional feature macro: TONE_PLAYER_GAP_EN
//   defined   -> GAP state inserts GAP_MS ms of silence after each completed note
//   undefined -> PLAY returns straight to IDLE, GAP_MS has no effect
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high; clears all state
//   in_valid  command valid
//   in_ready  command can be accepted (combinational: IDLE && !stop)
//   note      0 = rest, 1..12 = C..B, 13..15 = rest
//   octave    0 = C4..B4, each step doubles the frequency
//   dur       note length in ms
//   stop      abort the current note (no done pulse)
//   buzz      square-wave buzzer drive
//   busy      high whenever not IDLE
//   done      one-cycle pulse on normal completion
module tone_player #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = 18,
    parameter int unsigned DUR_W  = 12,
    parameter int unsigned GAP_MS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    input  logic [DUR_W-1:0] dur,
    input  logic             stop,
    output logic             buzz,
    output logic             busy,
    output logic             done
);

    // Cycles per millisecond; very slow clocks tick every cycle.
    localparam int unsigned MS_CYC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1
`ifdef TONE_PLAYER_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DIV_W-1:0]   tone_cnt;
    logic [DIV_W-1:0]   half_q;
    logic [PRE_W-1:0]   pre_cnt;
    logic [DUR_W-1:0]   ms_cnt;
    logic [DUR_W-1:0]   dur_q;
    logic               rest_q;
    logic               buzz_q;
    logic               busy_q;
    logic               done_q;

    logic               buzz_nxt;
    logic               done_nxt;
    logic               accept;
    logic               tick;
    logic               tone_wrap;

`ifdef TONE_PLAYER_GAP_EN
    localparam int unsigned GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
    logic [GAP_W-1:0]   gap_cnt;
`else
    // GAP_MS only matters when the gap state is built.
    logic               unused_gap_ms;
    assign unused_gap_ms = ^GAP_MS;
`endif

    // Half period for a note/octave: floor(CLK_HZ/(2*F)) >> octave, at least 1.
    function automatic logic [DIV_W-1:0] half_of(input logic [3:0] n, input logic [1:0] oct);
        int unsigned      f;
        logic [DIV_W-1:0] h;
        f = 262;
        case (n)
            4'd1:    f = 262;
            4'd2:    f = 277;
            4'd3:    f = 294;
            4'd4:    f = 311;
            4'd5:    f = 330;
            4'd6:    f = 349;
            4'd7:    f = 370;
            4'd8:    f = 392;
            4'd9:    f = 415;
            4'd10:   f = 440;
            4'd11:   f = 466;
            4'd12:   f = 494;
            default: f = 262;   // rests: value is never used for the output
        endcase
        h = DIV_W'(CLK_HZ / (2 * f)) >> oct;
        return (h == '0) ? DIV_W'(1) : h;
    endfunction

    assign in_ready  = (state == IDLE) && !stop;
    assign accept    = in_valid && in_ready;
    assign tick      = (pre_cnt == PRE_W'(MS_CYC - 1));
    assign tone_wrap = (tone_cnt == half_q - DIV_W'(1));

    assign buzz = buzz_q;
    assign busy = busy_q;
    assign done = done_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next output values; stop outranks completion.
    always_comb begin
        state_nxt = state;
        buzz_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (ms_cnt == dur_q) begin
`ifdef TONE_PLAYER_GAP_EN
                    state_nxt = GAP;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end else begin
                    buzz_nxt = rest_q ? 1'b0 : (buzz_q ^ tone_wrap);
                end
            end
`ifdef TONE_PLAYER_GAP_EN
            GAP: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == GAP_W'(GAP_MS)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counters, latched command and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tone_cnt <= '0;
            half_q   <= '0;
            pre_cnt  <= '0;
            ms_cnt   <= '0;
            dur_q    <= '0;
            rest_q   <= 1'b0;
            buzz_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            buzz_q <= buzz_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= done_nxt;
            if (accept) begin
                tone_cnt <= '0;
                pre_cnt  <= '0;
                ms_cnt   <= '0;
                dur_q    <= dur;
                half_q   <= half_of(note, octave);
                rest_q   <= (note == 4'd0) || (note > 4'd12);
            end else if (state == PLAY) begin
                tone_cnt <= tone_wrap ? '0 : tone_cnt + DIV_W'(1);
                pre_cnt  <= tick ? '0 : pre_cnt + PRE_W'(1);
                if (tick) begin
                    ms_cnt <= ms_cnt + DUR_W'(1);
                end
`ifdef TONE_PLAYER_GAP_EN
                // Gap timing starts from a fresh millisecond.
                if (state_nxt == GAP) begin
                    pre_cnt <= '0;
                    gap_cnt <= '0;
                end
`endif
            end
`ifdef TONE_PLAYER_GAP_EN
            else if (state == GAP) begin
                pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
                if (tick) begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player (CLK_HZ = 100_000, GAP_MS = 2).
// A timing model predicts buzz/busy/done/in_ready from accept edge, note
// frequency and duration; directed cases pin literal values.
module tb_tone_player;

    localparam int TB_CLK = 100_000;
    localparam int MS     = TB_CLK / 1000;
    localparam int GAPMS  = 2;
`ifdef TONE_PLAYER_GAP_EN
    localparam int GAP_EDGES = GAPMS * MS + 1;
`else
    localparam int GAP_EDGES = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  note;
    logic [1:0]  octave;
    logic [11:0] dur;
    logic        stop;
    logic        buzz;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    tone_player #(
        .CLK_HZ (TB_CLK),
        .DIV_W  (18),
        .DUR_W  (12),
        .GAP_MS (GAPMS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .note     (note),
        .octave   (octave),
        .dur      (dur),
        .stop     (stop),
        .buzz     (buzz),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int freq_tab [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

    function automatic int model_half(input int n, input int o);
        int h;
        h = (TB_CLK / (2 * freq_tab[n - 1])) >> o;
        if (h < 1) h = 1;
        return h;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a note is a window of edges [m_n, m_end]; tone and exit are arithmetic.
    int cyc = 0;
    bit m_act = 1'b0;
    bit m_done = 1'b0;
    bit m_rest = 1'b0;
    int m_n, m_exit, m_end, m_half;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act  = 1'b0;
            m_done = 1'b0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_act) begin
                if (stop) begin
                    m_act = 1'b0;
                end else if (cyc == m_end) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end else if (in_valid && !stop) begin
                m_act  = 1'b1;
                m_n    = cyc;
                m_rest = (note == 4'd0) || (note > 4'd12);
                m_half = m_rest ? 1 : model_half(int'(note), int'(octave));
                m_exit = cyc + int'(dur) * MS + 1;
                m_end  = m_exit + GAP_EDGES;
            end
        end
    end

    int eb;
    always @(negedge clk) begin
        if (chk_en) begin
            eb = 0;
            if (m_act && cyc < m_exit && !m_rest) eb = ((cyc - m_n) / m_half) % 2;
            cmp("buzz", int'(buzz), eb);
            cmp("busy", int'(busy), int'(m_act));
            cmp("done", int'(done), int'(m_done));
            cmp("in_ready", int'(in_ready), int'(!m_act && !stop));
        end
    end

    // Wait for in_ready, present one command for one cycle; returns at accept edge + 1.
    task automatic send(input logic [3:0] n, input logic [1:0] o, input logic [11:0] d);
        int w;
        w = 0;
        while (!in_ready && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        cmp("send_ready", int'(in_ready), 1);
        note = n; octave = o; dur = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int edges);
        edges = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    int e;
    bit found;

    initial begin
        reset = 1'b0; in_valid = 1'b0; stop = 1'b0;
        note = '0; octave = '0; dur = '0;
        #2 reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_buzz", int'(buzz), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_done", int'(done), 0);
        cmp("rst_ready", int'(in_ready), 1);
        reset = 1'b0;

        cmp("pin_half_A4", model_half(10, 0), 113);
        cmp("pin_half_C5", model_half(1, 1), 95);

        // A4, 3 ms
        send(4'd10, 2'd0, 12'd3);
        cmp("a_busy_k0", int'(busy), 1);
        cmp("a_buzz_k0", int'(buzz), 0);
        repeat (112) @(posedge clk);
        #1 cmp("a_buzz_k112", int'(buzz), 0);
        @(posedge clk);
        #1 cmp("a_buzz_k113", int'(buzz), 1);
        repeat (113) @(posedge clk);
        #1 cmp("a_buzz_k226", int'(buzz), 0);
        wait_done(1000, e);
        cmp("a_done_edge", (e < 0) ? -1 : 226 + e, 301 + GAP_EDGES);

        // C5, 1 ms
        send(4'd1, 2'd1, 12'd1);
        repeat (94) @(posedge clk);
        #1 cmp("c_buzz_k94", int'(buzz), 0);
        @(posedge clk);
        #1 cmp("c_buzz_k95", int'(buzz), 1);
        wait_done(1000, e);
        cmp("c_done_edge", (e < 0) ? -1 : 95 + e, 101 + GAP_EDGES);

        // rest, 2 ms
        send(4'd0, 2'd2, 12'd2);
        wait_done(1000, e);
        cmp("rest_done_edge", e, 201 + GAP_EDGES);

        // zero duration
        send(4'd5, 2'd0, 12'd0);
        cmp("dur0_busy_k0", int'(busy), 1);
        wait_done(1000, e);
        cmp("dur0_done_edge", e, 1 + GAP_EDGES);

        // stop 50 cycles into a 5 ms note; in_valid held with stop in IDLE
        send(4'd3, 2'd0, 12'd5);
        repeat (49) @(posedge clk);
        #1;
        stop = 1'b1; in_valid = 1'b1; note = 4'd7; dur = 12'd1;
        @(posedge clk);
        #1;
        cmp("stop_busy", int'(busy), 0);
        cmp("stop_buzz", int'(buzz), 0);
        cmp("stop_done", int'(done), 0);
        cmp("stop_ready", int'(in_ready), 0);
        repeat (3) begin
            @(posedge clk);
            #1 cmp("stop_hold_busy", int'(busy), 0);
        end
        stop = 1'b0; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // async reset while buzz is high (B7, HALF = 12)
        send(4'd12, 2'd3, 12'd5);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            found = buzz;
        end
        cmp("rm_buzz_high", int'(found), 1);
        #1 reset = 1'b1;
        #1;
        cmp("rm_buzz", int'(buzz), 0);
        cmp("rm_busy", int'(busy), 0);
        cmp("rm_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 cmp("rm_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // random traffic, including commands and input changes while busy
        for (int i = 0; i < 12000; i++) begin
            in_valid = ($urandom_range(3, 0) == 0);
            note     = 4'($urandom);
            octave   = 2'($urandom);
            dur      = 12'($urandom_range(3, 0));
            stop     = ($urandom_range(299, 0) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; stop = 1'b0;
        repeat (700) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
